// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD command-line engine.
//   - resp_type encodings, engine state enum
//   - frame lengths (48-bit command/short response, 136-bit long response)
//   - CRC7 generator polynomial x^7 + x^3 + 1
package sd_cmd_pkg;

    typedef enum logic [1:0] {
        RESP_NONE       = 2'd0,
        RESP_SHORT      = 2'd1,
        RESP_LONG       = 2'd2,
        RESP_SHORT_BUSY = 2'd3
    } resp_type_e;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RESP,
        RECV,
        RESP_HS,
        DONE_HS,
        GAP
    } state_e;

    localparam int SHORT_FRAME_LEN = 48;
    localparam int LONG_FRAME_LEN  = 136;
    // Number of leading command bits protected by the CRC7.
    localparam int TX_CRC_BITS     = 40;

    // Low 7 coefficients of x^7 + x^3 + 1.
    localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_cmd_engine_if.sv
// Host/card-facing signal bundle of sd_cmd_engine.
//   master : host side (drives command request, acks, bit tick, cmd_pin_in)
//   slave  : engine side (drives cmd line, response, status flags)
interface sd_cmd_engine_if;
    logic         sd_clk_en;
    logic         new_command;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_argument;
    logic [1:0]   resp_type;
    logic         timeout_enable;
    logic         cmd_pin_in;
    logic         cmd_pin_out;
    logic         cmd_oe;
    logic [127:0] response;
    logic         enable_response;
    logic         ack_response;
    logic         command_complete;
    logic         enable_command_complete;
    logic         ack_command_complete;
    logic         no_response;
    logic         crc_error;
    logic         busy;

    modport master (
        output sd_clk_en, new_command, cmd_index, cmd_argument, resp_type,
               timeout_enable, cmd_pin_in, ack_response, ack_command_complete,
        input  cmd_pin_out, cmd_oe, response, enable_response, command_complete,
               enable_command_complete, no_response, crc_error, busy
    );

    modport slave (
        input  sd_clk_en, new_command, cmd_index, cmd_argument, resp_type,
               timeout_enable, cmd_pin_in, ack_response, ack_command_complete,
        output cmd_pin_out, cmd_oe, response, enable_response, command_complete,
               enable_command_complete, no_response, crc_error, busy
    );
endinterface

// File: rtl/sd_cmd_engine_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, seed 0), one bit per enabled clock.
// Ports: clock, reset (async active-low), clear_i (synchronous clear to 0,
// wins over enable_i), enable_i, data_i (serial bit), crc_o[6:0].
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic       data_i,
    output logic [6:0] crc_o
);
    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = crc_q[6] ^ data_i;
        crc_d = crc_q;
        if (clear_i)
            crc_d = '0;
        else if (enable_i)
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) crc_q <= '0;
        else        crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/sd_cmd_engine.sv
// SD command-line engine: serialises a 48-bit command (with CRC7), waits for
// and receives a short/long response, then handshakes response and completion.
// Ports: clock, reset (async active-low), bus (sd_cmd_engine_if.slave).
// Parameters: TIMEOUT_TICKS (response wait limit), NCC_TICKS (post-command gap).
// Optional: define SD_CMD_CRC7_CHECK_EN to check the received CRC7; otherwise
// crc_error is tied low and no receive CRC hardware exists.
module sd_cmd_engine
    import sd_cmd_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 64,
    parameter int NCC_TICKS     = 8
) (
    input  logic              clock,
    input  logic              reset,
    sd_cmd_engine_if.slave    bus
);
    localparam int            TW   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMAX = '1;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_TICKS);

    state_e       state_q, state_d;
    resp_type_e   resp_q, resp_d;
    logic [38:0]  tx_sr_q, tx_sr_d;     // bits still to send after the one on the pin
    logic         pin_q, pin_d;
    logic [7:0]   bit_cnt_q, bit_cnt_d; // frame bit index, reused as gap counter
    logic [TW-1:0] tick_q, tick_d;
    logic [TW-1:0] t_inc;
    logic [126:0] rx_sr_q, rx_sr_d;     // last 127 received bits
    logic [127:0] response_q, response_d;
    logic         no_resp_q, no_resp_d;

    logic         tick, accept, is_long;
    logic [7:0]   frame_len;
    logic         tx_crc_en, tx_crc_bit;
    logic [6:0]   tx_crc;

    assign tick      = bus.sd_clk_en;
    assign accept    = (state_q == IDLE) && bus.new_command;
    assign is_long   = (resp_q == RESP_LONG);
    assign frame_len = is_long ? 8'(LONG_FRAME_LEN) : 8'(SHORT_FRAME_LEN);

    // Clearing on accept guarantees every frame starts from seed 0.
    sd_crc7 u_tx_crc (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (accept),
        .enable_i (tx_crc_en),
        .data_i   (tx_crc_bit),
        .crc_o    (tx_crc)
    );

`ifdef SD_CMD_CRC7_CHECK_EN
    logic       rx_crc_en;
    logic [6:0] rx_crc;
    logic       crc_err_q, crc_err_d;

    // Short: start..argument (bits 47:8). Long: payload bits 127:8, i.e.
    // frame indices 8..127 counted from the start bit.
    assign rx_crc_en = tick && (state_q == RECV) &&
                       (is_long ? (bit_cnt_q >= 8'd8 && bit_cnt_q < 8'd128)
                                : (bit_cnt_q < 8'(TX_CRC_BITS)));

    sd_crc7 u_rx_crc (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (accept),
        .enable_i (rx_crc_en),
        .data_i   (bus.cmd_pin_in),
        .crc_o    (rx_crc)
    );
    assign bus.crc_error = crc_err_q;
`else
    assign bus.crc_error = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        resp_d     = resp_q;
        tx_sr_d    = tx_sr_q;
        pin_d      = pin_q;
        bit_cnt_d  = bit_cnt_q;
        tick_d     = tick_q;
        rx_sr_d    = rx_sr_q;
        response_d = response_q;
        no_resp_d  = no_resp_q;
        tx_crc_en  = 1'b0;
        tx_crc_bit = 1'b0;
        t_inc      = (tick_q == TMAX) ? tick_q : tick_q + 1'b1;
`ifdef SD_CMD_CRC7_CHECK_EN
        crc_err_d  = crc_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.new_command) begin
                    // Start bit goes on the pin immediately; it is 0 so it
                    // leaves the zero-seeded CRC unchanged.
                    tx_sr_d   = {1'b1, bus.cmd_index, bus.cmd_argument};
                    resp_d    = resp_type_e'(bus.resp_type);
                    pin_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: if (tick) begin
                bit_cnt_d = bit_cnt_q + 8'd1;
                if (bit_cnt_q == 8'd39) begin
                    // CRC now covers bits 0..39: splice it plus end bit in.
                    pin_d   = tx_crc[6];
                    tx_sr_d = {tx_crc[5:0], 1'b1, 32'd0};
                end else if (bit_cnt_q < 8'd47) begin
                    pin_d      = tx_sr_q[38];
                    tx_sr_d    = {tx_sr_q[37:0], 1'b0};
                    tx_crc_en  = (bit_cnt_q < 8'd39);
                    tx_crc_bit = tx_sr_q[38];
                end else begin
                    pin_d   = 1'b1;
                    tick_d  = '0;
                    state_d = (resp_q == RESP_NONE) ? DONE_HS : WAIT_RESP;
                end
            end
            WAIT_RESP: if (tick) begin
                if (!bus.cmd_pin_in) begin
                    rx_sr_d   = {rx_sr_q[125:0], 1'b0};
                    bit_cnt_d = 8'd1;
                    state_d   = RECV;
                end else if (bus.timeout_enable) begin
                    tick_d = t_inc;
                    if (t_inc >= TLIM) begin
                        no_resp_d = 1'b1;
                        state_d   = DONE_HS;
                    end
                end
            end
            RECV: if (tick) begin
                rx_sr_d   = {rx_sr_q[125:0], bus.cmd_pin_in};
                bit_cnt_d = bit_cnt_q + 8'd1;
                if (bit_cnt_q + 8'd1 == frame_len) begin
                    // cmd_pin_in is the end bit; rx_sr_q holds frame[127:1].
                    response_d = is_long ? {rx_sr_q, 1'b0}
                                         : {96'd0, rx_sr_q[38:7]};
`ifdef SD_CMD_CRC7_CHECK_EN
                    crc_err_d  = (rx_crc != rx_sr_q[6:0]);
`endif
                    state_d    = RESP_HS;
                end
            end
            RESP_HS: begin
                if (bus.ack_response) state_d = DONE_HS;
            end
            DONE_HS: begin
                if (bus.ack_command_complete) begin
                    no_resp_d = 1'b0;
`ifdef SD_CMD_CRC7_CHECK_EN
                    crc_err_d = 1'b0;
`endif
                    bit_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: if (tick) begin
                bit_cnt_d = bit_cnt_q + 8'd1;
                if (int'(bit_cnt_q) + 1 >= NCC_TICKS) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            resp_q     <= RESP_NONE;
            tx_sr_q    <= '0;
            pin_q      <= 1'b1;
            bit_cnt_q  <= '0;
            tick_q     <= '0;
            rx_sr_q    <= '0;
            response_q <= '0;
            no_resp_q  <= 1'b0;
`ifdef SD_CMD_CRC7_CHECK_EN
            crc_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            resp_q     <= resp_d;
            tx_sr_q    <= tx_sr_d;
            pin_q      <= pin_d;
            bit_cnt_q  <= bit_cnt_d;
            tick_q     <= tick_d;
            rx_sr_q    <= rx_sr_d;
            response_q <= response_d;
            no_resp_q  <= no_resp_d;
`ifdef SD_CMD_CRC7_CHECK_EN
            crc_err_q  <= crc_err_d;
`endif
        end
    end

    assign bus.cmd_oe                  = (state_q == SEND);
    assign bus.cmd_pin_out             = pin_q;
    assign bus.busy                    = (state_q != IDLE);
    assign bus.enable_response         = (state_q == RESP_HS);
    assign bus.command_complete        = (state_q == DONE_HS);
    assign bus.enable_command_complete = (state_q == DONE_HS);
    assign bus.response                = response_q;
    assign bus.no_response             = no_resp_q;
endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: command serialisation, short/long
// responses, timeout, handshakes, gap, and asynchronous reset mid-frame.
module tb_sd_cmd_engine;
    logic clock = 1'b0;
    logic reset = 1'b0;
    sd_cmd_engine_if bus();

    int errors = 0;
    int checks = 0;

    logic [47:0] cap = '0;   // last 48 bits seen on the cmd line while driven
    int          cap_n = 0;
    int          enr_cnt = 0;

    sd_cmd_engine #(.TIMEOUT_TICKS(64), .NCC_TICKS(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Bit tick every 4th clock, changed just after posedge.
    initial begin
        int div = 0;
        bus.sd_clk_en = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            bus.sd_clk_en = (div == 3);
            div = (div + 1) % 4;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (bus.sd_clk_en && bus.cmd_oe) begin
                cap   = {cap[46:0], bus.cmd_pin_out};
                cap_n = cap_n + 1;
            end
            if (bus.enable_response) enr_cnt = enr_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // code 0: cmd_oe low, 1: enable_response, 2: enable_command_complete, 3: busy low
    task automatic wait_for(input int code, input int max_cyc, input string tag, output int ticks);
        int  n = 0;
        bit  hit = 1'b0;
        ticks = 0;
        while (1) begin
            case (code)
                0:       hit = !bus.cmd_oe;
                1:       hit = bus.enable_response;
                2:       hit = bus.enable_command_complete;
                default: hit = !bus.busy;
            endcase
            if (hit || n >= max_cyc) break;
            if (bus.sd_clk_en) ticks++;
            @(negedge clock);
            n++;
        end
        if (!hit) check({tag, "_timeout"}, 128'd0, 128'd1);
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
        @(negedge clock);
        bus.cmd_index = idx; bus.cmd_argument = arg; bus.resp_type = rt;
        bus.new_command = 1'b1;
        @(negedge clock);
        bus.new_command = 1'b0;
    endtask

    task automatic ack_resp();
        @(negedge clock); bus.ack_response = 1'b1;
        @(negedge clock); bus.ack_response = 1'b0;
    endtask

    task automatic ack_cc();
        @(negedge clock); bus.ack_command_complete = 1'b1;
        @(negedge clock); bus.ack_command_complete = 1'b0;
    endtask

    task automatic drive_resp(input logic [135:0] f, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            while (!bus.sd_clk_en) @(negedge clock);
            bus.cmd_pin_in = f[i];
            @(negedge clock);
        end
        bus.cmd_pin_in = 1'b1;
    endtask

    initial begin
        int t;
        int base;
        logic exp_crc;
        bus.new_command = 0; bus.cmd_index = 0; bus.cmd_argument = 0;
        bus.resp_type = 0; bus.timeout_enable = 1; bus.cmd_pin_in = 1;
        bus.ack_response = 0; bus.ack_command_complete = 0;
        repeat (3) @(negedge clock);
        check("reset_flags", {bus.busy, bus.enable_response, bus.enable_command_complete,
              bus.command_complete, bus.no_response, bus.crc_error, bus.cmd_oe}, 0);
        check("reset_pin", bus.cmd_pin_out, 1);
        check("reset_resp", bus.response, 0);
        reset = 1'b1;
        @(negedge clock);

        // CMD0, no response
        base = cap_n;
        issue(6'd0, 32'h0, 2'd0);
        wait_for(2, 1000, "cmd0_cc", t);
        check("cmd0_ticks", t, 48);
        check("cmd0_frame", cap, 48'h400000000095);
        check("cmd0_bits", cap_n - base, 48);
        check("cmd0_noresp", bus.no_response, 0);
        check("cmd0_busy", bus.busy, 1);
        ack_resp();   // stray ack must not disturb completion
        check("cmd0_stray_ack", bus.enable_command_complete, 1);
        ack_cc();
        check("cmd0_cc_clr", {bus.enable_command_complete, bus.command_complete}, 0);
        wait_for(3, 500, "cmd0_gap", t);
        check("cmd0_gap_ticks", t, 8);
        $display("txn CMD0 frame=%h", cap);

        // CMD8 short response; delayed ack; new_command while busy
        issue(6'd8, 32'h000001AA, 2'd1);
        wait_for(0, 1000, "cmd8_tx", t);
        check("cmd8_frame", cap, 48'h48000001AA87);
        check("cmd8_crc_byte", cap[7:0], 8'h87);
        drive_resp({88'd0, 48'h08000001AA13}, 48);
        wait_for(1, 200, "cmd8_er", t);
        check("cmd8_resp", bus.response, 128'h1AA);
        check("cmd8_crc_err", bus.crc_error, 0);
        base = cap_n;
        issue(6'd17, 32'hDEADBEEF, 2'd1);
        ack_cc();     // no completion pending: ignored
        repeat (6) @(negedge clock);
        check("cmd8_er_hold", bus.enable_response, 1);
        check("cmd8_resp_hold", bus.response, 128'h1AA);
        check("cmd8_cc_early", bus.command_complete, 0);
        ack_resp();
        check("cmd8_er_drop", {bus.enable_response, bus.enable_command_complete}, 2'b01);
        ack_cc();
        wait_for(3, 500, "cmd8_gap", t);
        check("cmd8_gap_ticks", t, 8);
        repeat (20) @(negedge clock);
        check("cmd8_ignored_busy", bus.busy, 0);
        check("cmd8_ignored_tx", cap_n - base, 0);
        $display("txn CMD8 resp=%h", bus.response);

        // CMD8 with bad reply CRC
`ifdef SD_CMD_CRC7_CHECK_EN
        exp_crc = 1'b1;
`else
        exp_crc = 1'b0;
`endif
        issue(6'd8, 32'h000001AA, 2'd1);
        wait_for(0, 1000, "bad_tx", t);
        drive_resp({88'd0, 48'h08000001AA15}, 48);
        wait_for(1, 200, "bad_er", t);
        check("bad_crc_err", bus.crc_error, exp_crc);
        check("bad_resp", bus.response, 128'h1AA);
        ack_resp();
        ack_cc();
        check("bad_crc_clr", bus.crc_error, 0);
        wait_for(3, 500, "bad_gap", t);
        $display("txn CMD8-badcrc crc_error_expected=%0d", exp_crc);

        // Long response mapping
        issue(6'd2, 32'h0, 2'd2);
        wait_for(0, 1000, "long_tx", t);
        drive_resp({8'h3F, 128'h0123456789ABCDEFFEDCBA9876543211}, 136);
        wait_for(1, 200, "long_er", t);
        check("long_resp", bus.response, 128'h0123456789ABCDEFFEDCBA9876543210);
        check("long_noresp", bus.no_response, 0);
        ack_resp();
        ack_cc();
        wait_for(3, 500, "long_gap", t);
        $display("txn CMD2 resp=%h", bus.response);

        // Long response, timeout
        base = enr_cnt;
        issue(6'd2, 32'h0, 2'd2);
        wait_for(0, 1000, "to_tx", t);
        wait_for(2, 1000, "to_cc", t);
        check("to_ticks", t, 64);
        check("to_noresp", bus.no_response, 1);
        check("to_no_er", enr_cnt - base, 0);
        ack_cc();
        check("to_noresp_clr", bus.no_response, 0);
        wait_for(3, 500, "to_gap", t);
        $display("txn CMD2-timeout no_response seen");

        // Timeout disabled: unbounded wait, then recover with reset
        bus.timeout_enable = 1'b0;
        issue(6'd2, 32'h0, 2'd2);
        wait_for(0, 1000, "nto_tx", t);
        repeat (500) @(negedge clock);
        check("nto_busy", {bus.busy, bus.enable_command_complete, bus.no_response}, 3'b100);
        reset = 1'b0;
        #1;
        check("nto_reset_busy", bus.busy, 0);
        @(negedge clock);
        reset = 1'b1;
        bus.timeout_enable = 1'b1;
        $display("txn CMD2-notimeout busy held");

        // Reset mid-frame, then a clean frame
        base = cap_n;
        issue(6'd17, 32'h12345678, 2'd1);
        t = 0;
        while (cap_n - base < 20 && t < 1000) begin @(negedge clock); t++; end
        check("mid_reached", cap_n - base >= 20, 1);
        reset = 1'b0;
        #1;
        check("mid_oe", bus.cmd_oe, 0);
        check("mid_pin", bus.cmd_pin_out, 1);
        check("mid_busy", bus.busy, 0);
        @(negedge clock);
        reset = 1'b1;
        base = cap_n;
        issue(6'd8, 32'h000001AA, 2'd0);
        wait_for(2, 1000, "post_cc", t);
        check("post_frame", cap, 48'h48000001AA87);
        check("post_bits", cap_n - base, 48);
        ack_cc();
        wait_for(3, 500, "post_gap", t);
        $display("txn CMD8-after-reset frame=%h", cap);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
